// File: rtl/if_fetch_pkg.sv
// Shared types, widths and constants for the instruction-fetch front end.
// Optional build macro used by if_fetch: IF_PERF_CNT_EN (fetch/bubble counters).
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'd4;
  localparam logic [INST_W-1:0]      ZERO_WORD = 32'h0000_0000;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic {
    RST_WAIT = 1'b0,
    RUN      = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD  = 2'd0,
    IFID_CLEAR = 2'd1,
    IFID_LOAD  = 2'd2
  } ifid_op_e;

  // Flush beats everything; a lone stall_id is an illegal ctrl code and is treated as a hold.
  function automatic ifid_op_e ifid_op(input fetch_state_e state, input logic flush,
                                       input logic stall_if, input logic stall_id);
    if (state != RUN)              return IFID_HOLD;
    if (flush)                     return IFID_CLEAR;
    if (stall_if && !stall_id)     return IFID_CLEAR;
    if (stall_if || stall_id)      return IFID_HOLD;
    return IFID_LOAD;
  endfunction

endpackage

// File: rtl/if_fetch_if_id_reg.sv
// IF/ID pipeline register: holds, clears (bubble/flush) or loads {pc, inst}.
module if_id_reg
  import if_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             i_op,
  input  logic [INST_ADDR_W-1:0] i_pc,
  input  logic [INST_W-1:0]      i_inst,
  output logic [INST_ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0]      o_inst,
  output logic                   o_valid
);

  logic [INST_ADDR_W-1:0] r_pc;
  logic [INST_W-1:0]      r_inst;
  logic                   r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_inst  <= ZERO_WORD;
      r_valid <= 1'b0;
    end else begin
      case (i_op)
        IFID_CLEAR: begin
          r_pc    <= RESET_PC;
          r_inst  <= ZERO_WORD;
          r_valid <= 1'b0;
        end
        IFID_LOAD: begin
          r_pc    <= i_pc;
          r_inst  <= i_inst;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC, ROM chip enable, and the IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch_cnt / bubble_cnt performance counters.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_if,
  input  logic                   stall_id,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  input  logic [INST_W-1:0]      inst_i,
  output logic [INST_ADDR_W-1:0] pc,
  output logic                   ce,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            bubble_cnt
`endif
);

  fetch_state_e           r_state;
  logic [INST_ADDR_W-1:0] r_pc;
  logic                   r_ce;
  ifid_op_e               w_op;

  assign w_op = ifid_op(r_state, flush, stall_if, stall_id);

  // A branch seen alongside any stall is dropped; ctrl re-presents it after the stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RST_WAIT;
      r_pc    <= RESET_PC;
      r_ce    <= CHIP_DISABLE;
    end else if (r_state == RST_WAIT) begin
      r_state <= RUN;
      r_ce    <= CHIP_ENABLE;
    end else begin
      if (flush)                   r_pc <= new_pc;
      else if (stall_if || stall_id) r_pc <= r_pc;
      else if (branch_flag_i)      r_pc <= branch_target_address_i;
      else                         r_pc <= r_pc + PC_STEP;
    end
  end

  assign pc = r_pc;
  assign ce = r_ce;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst),
    .i_op    (w_op),
    .i_pc    (r_pc),
    .i_inst  (inst_i),
    .o_pc    (id_pc),
    .o_inst  (id_inst),
    .o_valid (id_valid)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (w_op == IFID_LOAD)  r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (w_op == IFID_CLEAR) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table, async-reset checks,
// then randomized traffic compared against a behavioural fetch model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, flush, branch_flag_i;
  logic [31:0] new_pc, branch_target_address_i, inst_i;
  logic [31:0] pc, id_pc, id_inst;
  logic        ce, id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3401_1100;
      32'h0000_0004: return 32'h3402_0020;
      default:       return 32'hAC00_0000 ^ a;
    endcase
  endfunction

  assign inst_i = rom(pc);

  if_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_if                (stall_if),
    .stall_id                (stall_id),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .inst_i                  (inst_i),
    .pc                      (pc),
    .ce                      (ce),
    .id_pc                   (id_pc),
    .id_inst                 (id_inst),
    .id_valid                (id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt               (fetch_cnt),
    .bubble_cnt              (bubble_cnt)
`endif
  );

  // Behavioural model of the fetch front end
  logic        m_run, m_ce, m_id_valid;
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_fetch, m_bubble;

  task automatic model_reset();
    m_run = 0; m_ce = 0; m_pc = 0;
    m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
    m_fetch = 0; m_bubble = 0;
  endtask

  task automatic model_edge();
    logic [31:0] word;
    word = rom(m_pc);
    if (!m_run) begin
      m_run = 1; m_ce = 1;
    end else if (flush || (stall_if && !stall_id)) begin
      if (flush) m_pc = new_pc;
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
      m_bubble = m_bubble + 1;
    end else if (!(stall_if || stall_id)) begin
      m_id_pc = m_pc; m_id_inst = word; m_id_valid = 1;
      m_fetch = m_fetch + 1;
      m_pc = branch_flag_i ? branch_target_address_i : m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".ce"}, {31'd0, ce}, {31'd0, m_ce});
    chk({tag, ".id_pc"}, id_pc, m_id_pc);
    chk({tag, ".id_inst"}, id_inst, m_id_inst);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_id_valid});
`ifdef IF_PERF_CNT_EN
    chk({tag, ".fetch_cnt"}, fetch_cnt, m_fetch);
    chk({tag, ".bubble_cnt"}, bubble_cnt, m_bubble);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic f, input logic si, input logic sd, input logic br,
                        input logic [31:0] tgt, input logic [31:0] npc);
    flush = f; stall_if = si; stall_id = sd; branch_flag_i = br;
    branch_target_address_i = tgt; new_pc = npc;
  endtask

  typedef struct {
    logic        flush, sif, sid, br;
    logic [31:0] tgt, npc;
    logic [31:0] e_pc, e_id_pc, e_id_inst;
    logic        e_valid;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // flush sif sid br  target        new_pc   | pc            id_pc         id_inst       valid
    vecs[0]  = '{0,0,0,0, 32'h0,        32'h0,  32'h0,        32'h0,        32'h0,        0};
    vecs[1]  = '{0,0,0,0, 32'h0,        32'h0,  32'h4,        32'h0,        32'h34011100, 1};
    vecs[2]  = '{0,0,0,0, 32'h0,        32'h0,  32'h8,        32'h4,        32'h34020020, 1};
    vecs[3]  = '{0,0,0,1, 32'h40,       32'h0,  32'h40,       32'h8,        32'hAC000008, 1};
    vecs[4]  = '{0,0,0,0, 32'h0,        32'h0,  32'h44,       32'h40,       32'hAC000040, 1};
    vecs[5]  = '{0,0,0,1, 32'hC,        32'h0,  32'hC,        32'h44,       32'hAC000044, 1};
    vecs[6]  = '{0,1,1,0, 32'h0,        32'h0,  32'hC,        32'h44,       32'hAC000044, 1};
    vecs[7]  = '{0,1,1,0, 32'h0,        32'h0,  32'hC,        32'h44,       32'hAC000044, 1};
    vecs[8]  = '{0,1,1,0, 32'h0,        32'h0,  32'hC,        32'h44,       32'hAC000044, 1};
    vecs[9]  = '{0,1,0,0, 32'h0,        32'h0,  32'hC,        32'h0,        32'h0,        0};
    vecs[10] = '{0,0,0,0, 32'h0,        32'h0,  32'h10,       32'hC,        32'hAC00000C, 1};
    vecs[11] = '{1,1,0,1, 32'h40,       32'h20, 32'h20,       32'h0,        32'h0,        0};
    vecs[12] = '{0,0,0,0, 32'h0,        32'h0,  32'h24,       32'h20,       32'hAC000020, 1};
    vecs[13] = '{0,0,0,1, 32'hFFFFFFFC, 32'h0,  32'hFFFFFFFC, 32'h24,       32'hAC000024, 1};
    vecs[14] = '{0,0,0,0, 32'h0,        32'h0,  32'h0,        32'hFFFFFFFC, 32'h53FFFFFC, 1};
    vecs[15] = '{0,0,0,0, 32'h0,        32'h0,  32'h4,        32'h0,        32'h34011100, 1};
    vecs[16] = '{0,0,1,0, 32'h0,        32'h0,  32'h4,        32'h0,        32'h34011100, 1};
    vecs[17] = '{0,1,0,1, 32'h80,       32'h0,  32'h4,        32'h0,        32'h0,        0};

    rst = 1'b0;
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc", pc, 32'h0);
    chk("reset.ce", {31'd0, ce}, 32'd0);
    chk("reset.id_pc", id_pc, 32'h0);
    chk("reset.id_inst", id_inst, 32'h0);
    chk("reset.id_valid", {31'd0, id_valid}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].flush, vecs[i].sif, vecs[i].sid, vecs[i].br, vecs[i].tgt, vecs[i].npc);
      step();
      $display("vec %0d: pc=%h ce=%0b id={%h,%h,%0b}", i, pc, ce, id_pc, id_inst, id_valid);
      chk($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.ce", i), {31'd0, ce}, 32'd1);
      chk($sformatf("vec%0d.id_pc", i), id_pc, vecs[i].e_id_pc);
      chk($sformatf("vec%0d.id_inst", i), id_inst, vecs[i].e_id_inst);
      chk($sformatf("vec%0d.id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
    end
`ifdef IF_PERF_CNT_EN
    chk("vec.fetch_cnt", fetch_cnt, 32'd10);
    chk("vec.bubble_cnt", bubble_cnt, 32'd3);
`endif

    // Async reset mid-cycle: outputs must clear with no clock edge
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    #2;
    $display("async reset: pc=%h ce=%0b id={%h,%h,%0b}", pc, ce, id_pc, id_inst, id_valid);
    chk("async.pc", pc, 32'h0);
    chk("async.ce", {31'd0, ce}, 32'd0);
    chk("async.id_pc", id_pc, 32'h0);
    chk("async.id_inst", id_inst, 32'h0);
    chk("async.id_valid", {31'd0, id_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("async.fetch_cnt", fetch_cnt, 32'd0);
    chk("async.bubble_cnt", bubble_cnt, 32'd0);
`endif
    model_reset();
    rst = 1'b1;

    // Restart, 5 fetches then 2 bubbles
    step();
    chk_model("restart");
    for (int i = 0; i < 5; i++) begin
      step();
      $display("perf fetch %0d: pc=%h id={%h,%h,%0b}", i, pc, id_pc, id_inst, id_valid);
      chk_model("perf_fetch");
    end
    set_in(0, 1, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      $display("perf bubble %0d: pc=%h id={%h,%h,%0b}", i, pc, id_pc, id_inst, id_valid);
      chk_model("perf_bubble");
    end
`ifdef IF_PERF_CNT_EN
    chk("perf.fetch_cnt", fetch_cnt, 32'd5);
    chk("perf.bubble_cnt", bubble_cnt, 32'd2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic si;
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b0;
        #2;
        model_reset();
        chk_model("rand_rst");
        rst = 1'b1;
      end
      si = ($urandom_range(0, 4) == 0);
      set_in($urandom_range(0, 15) == 0,
             si,
             si ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0),
             $urandom_range(0, 3) == 0,
             ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'h0000_0FFC),
             $urandom);
      step();
      $display("rand %0d: f=%0b sif=%0b sid=%0b br=%0b pc=%h id={%h,%h,%0b}",
               i, flush, stall_if, stall_id, branch_flag_i, pc, id_pc, id_inst, id_valid);
      chk_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end for the five-stage MIPS core: owns the program counter, drives address and chip-enable to the instruction ROM, and registers the returned word with its PC into the IF/ID pipeline register for decode. Handles sequential fetch, ID-resolved branches with one delay slot, pipeline stalls with bubble insertion, and exception flush redirects.

## Interface
- No parameters. Widths come from `InstAddrBus` (32) and `InstBus` (32) in defines.v.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_if  in  1  IF stage stall from ctrl.
- stall_id  in  1  ID stage stall from ctrl.
- flush  in  1  exception flush from ctrl.
- new_pc  in  32  exception handler address; used only with flush.
- branch_flag_i  in  1  taken branch/jump resolved in ID.
- branch_target_address_i  in  32  branch/jump target.
- inst_i  in  32  instruction word from ROM, combinational on pc.
- pc  out  32  fetch address to ROM.
- ce  out  1  ROM chip enable.
- id_pc  out  32  PC of the instruction in IF/ID.
- id_inst  out  32  instruction in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- States: RST_WAIT, RUN.
- RST_WAIT, entered on reset: ce=0, pc=0x00000000. IF/ID stays empty. First edge with rst high moves to RUN with ce=1 and pc unchanged, so the first fetch is at 0x00000000.
- RUN: per edge, evaluate in this priority order:
  - flush: pc<=new_pc. IF/ID cleared (id_valid=0, id_inst=0, id_pc=0).
  - stall_if && stall_id: pc and IF/ID hold.
  - stall_if && !stall_id: pc holds. IF/ID loads a bubble (id_valid=0, id_inst=0, id_pc=0).
  - stall_id && !stall_if: illegal ctrl encoding. Treat as a full hold.
  - branch_flag_i: pc<=branch_target_address_i. IF/ID loads {pc, inst_i} (the delay slot), id_valid=1.
  - otherwise: pc<=pc+4. IF/ID loads {pc, inst_i}, id_valid=1.
- Arithmetic: pc+4 is modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000. Branch targets and new_pc are taken verbatim; alignment faults belong to a later stage.
- ce is never deasserted in RUN. Stalls hold pc, so inst_i stays valid.
- Reset mid-operation forces all outputs to reset values immediately, with no clock required, and returns to RST_WAIT.

## Timing
- Reset values: pc=0, ce=0, id_pc=0, id_inst=0, id_valid=0. Also fetch_cnt=0 and bubble_cnt=0 when enabled.
- ROM is combinational: the instruction at pc appears in IF/ID one edge after pc is presented. Fetch-to-decode latency is 1 cycle.
- A branch asserted in cycle N sets pc=target at edge N+1. The delay slot enters IF/ID at the same edge. The target instruction reaches IF/ID at edge N+2.
- A flush asserted together with a branch or stall: flush wins, and IF/ID is empty after that edge.
- A branch asserted together with any stall_if: ignored. ctrl keeps the branch asserted until the stall releases.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs fetch_cnt (32, increments on every edge that loads id_valid=1) and bubble_cnt (32, increments on every bubble or flush load). Both counters wrap modulo 2^32 and are cleared only by reset.
- Undefined: neither the ports nor the counter logic exist.

## Structure
- defines.v gains `ResetPC` (32'h00000000), `PcStep` (32'd4) and `FetchStateBus` (1-bit state encoding). Existing `ZeroWord`, `ChipEnable` and `ChipDisable` are reused.
- One sub-module, if_id_reg: the IF/ID register with hold/bubble/flush/load controls and async active-low reset.
- PC logic, state machine and counters stay in if_fetch.

## Test plan
- Reset release, no stalls, ROM words 0x34011100 at 0x0 and 0x34020020 at 0x4 -> ce rises one edge after release. IF/ID shows {0x0, 0x34011100, 1}, then {0x4, 0x34020020, 1}.
- branch_flag_i=1 with target 0x40 while pc=0x8 -> IF/ID gets {0x8, inst@0x8} (delay slot), then {0x40, inst@0x40}.
- stall_if=stall_id=1 for 3 cycles at pc=0xC -> pc and IF/ID frozen. stall_if=1 alone for 1 cycle -> one bubble with id_valid=0, pc still 0xC.
- flush with new_pc=0x20, asserted together with branch_flag_i and stall_if -> pc=0x20, IF/ID cleared, branch ignored.
- pc forced to 0xFFFFFFFC by branch -> next sequential pc is 0x00000000. Async rst pulse mid-run -> all outputs zero without a clock edge.
- IF_PERF_CNT_EN defined, 5 fetches and 2 bubbles -> fetch_cnt=5, bubble_cnt=2.
